// File: rtl/seq_detector_param.sv
// Serial pattern detector with a loadable, maskable pattern.
// It also keeps a saturating match counter with a sticky saturation flag.
module seq_detector_param #(
   parameter int             N            = 4,
   parameter int             OVERLAP      = 1,
   parameter int             CNT_W        = 8,
   parameter logic [N-1:0]   PATTERN_INIT = N'(4'b1001)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sequence_in,
   input  logic             in_valid,
   input  logic [N-1:0]     pattern,
   input  logic [N-1:0]     pattern_mask,
   input  logic             load,
   input  logic             clear_count,
   output logic             detector_out,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);

   localparam int              FILL_W   = (N > 2) ? $clog2(N) : 1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [N-1:0]      pat_q, pat_d;
   logic [N-1:0]      mask_q, mask_d;
   logic [N-2:0]      hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic              det_q, det_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sat_q, sat_d;

   logic [N-1:0]      window;
   logic [N-1:0]      bit_miss;
   logic              match;

   // Oldest history bit lines up with pattern bit N-1.
   assign window = {hist_q, sequence_in};

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_cmp
         assign bit_miss[gi] = (window[gi] ^ pat_q[gi]) & mask_q[gi];
      end
   endgenerate

   assign match = in_valid && !load && (fill_q == FILL_FULL) && (bit_miss == '0);

   always_comb begin
      pat_d  = pat_q;
      mask_d = mask_q;
      hist_d = hist_q;
      fill_d = fill_q;
      det_d  = match;
      cnt_d  = cnt_q;
      sat_d  = sat_q;

      if (load) begin
         pat_d  = pattern;
         mask_d = pattern_mask;
         hist_d = '0;
         fill_d = '0;
      end else if (in_valid) begin
         hist_d = window[N-2:0];
         if (match) begin
            fill_d = (OVERLAP != 0) ? FILL_FULL : '0;
         end else if (fill_q != FILL_FULL) begin
            fill_d = fill_q + FILL_W'(1);
         end
      end

      // A clear in the same cycle as a match leaves the counter at zero.
      if (clear_count) begin
         cnt_d = '0;
         sat_d = 1'b0;
      end else if (match) begin
         if (cnt_q == CNT_MAX) begin
            sat_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_q  <= PATTERN_INIT;
         mask_q <= '1;
         hist_q <= '0;
         fill_q <= '0;
         det_q  <= 1'b0;
         cnt_q  <= '0;
         sat_q  <= 1'b0;
      end else begin
         pat_q  <= pat_d;
         mask_q <= mask_d;
         hist_q <= hist_d;
         fill_q <= fill_d;
         det_q  <= det_d;
         cnt_q  <= cnt_d;
         sat_q  <= sat_d;
      end
   end

   assign detector_out = det_q;
   assign match_count  = cnt_q;
   assign count_sat    = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench: two detector instances (overlapping/8-bit counter and
// restarting/2-bit counter) share one stimulus stream and a behavioural model.
module tb_seq_detector_param;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          sequence_in = 1'b0;
   logic          in_valid = 1'b0;
   logic [N-1:0]  pattern = '0;
   logic [N-1:0]  pattern_mask = '0;
   logic          load = 1'b0;
   logic          clear_count = 1'b0;

   logic          det_a, det_b;
   logic [7:0]    cnt_a;
   logic [1:0]    cnt_b;
   logic          sat_a, sat_b;

   always #5 clk = ~clk;

   seq_detector_param #(.N(4), .OVERLAP(1), .CNT_W(8)) dut_a (
      .clk(clk), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
      .pattern(pattern), .pattern_mask(pattern_mask), .load(load),
      .clear_count(clear_count), .detector_out(det_a), .match_count(cnt_a),
      .count_sat(sat_a)
   );

   seq_detector_param #(.N(4), .OVERLAP(0), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .sequence_in(sequence_in), .in_valid(in_valid),
      .pattern(pattern), .pattern_mask(pattern_mask), .load(load),
      .clear_count(clear_count), .detector_out(det_b), .match_count(cnt_b),
      .count_sat(sat_b)
   );

   typedef struct {
      bit    da;
      int    ca;
      bit    sa;
      bit    db;
      int    cb;
      bit    sb;
      string tag;
   } exp_t;

   exp_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: history is simply "the last hlen valid bits" since restart.
   int unsigned hbits[2];
   int          hlen[2];
   int          mcnt[2];
   bit          msat[2];
   int          ov[2]   = '{1, 0};
   int          cmax[2] = '{255, 3};
   int unsigned mpat, mmask;

   function automatic void chk(string tag, string what, int act, int expv);
      n_cmp++;
      if (act != expv) begin
         n_bad++;
         $display("FAIL %s %s: got %0d expected %0d", tag, what, act, expv);
      end
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         hbits[m] = 0;
         hlen[m]  = 0;
         mcnt[m]  = 0;
         msat[m]  = 0;
      end
      mpat  = 4'b1001;
      mmask = 4'hF;
   endtask

   task automatic do_reset(input string tag);
      exp_t e;
      @(negedge clk);
      reset = 1'b0;
      in_valid = 1'b0; load = 1'b0; clear_count = 1'b0;
      model_reset();
      e.da = 0; e.ca = 0; e.sa = 0; e.db = 0; e.cb = 0; e.sb = 0; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic step(input bit v, input bit b, input bit ld, input int unsigned p,
                       input int unsigned mk, input bit clr, input string tag);
      exp_t        e;
      bit          hit[2];
      int unsigned win;
      @(negedge clk);
      reset        = 1'b1;
      in_valid     = v;
      sequence_in  = b;
      load         = ld;
      pattern      = p[N-1:0];
      pattern_mask = mk[N-1:0];
      clear_count  = clr;
      for (int m = 0; m < 2; m++) begin
         hit[m] = 0;
         if (ld) begin
            hbits[m] = 0;
            hlen[m]  = 0;
         end else if (v) begin
            if (hlen[m] >= N - 1) begin
               win = ((hbits[m] << 1) | int'(b)) & ((1 << N) - 1);
               hit[m] = 1;
               for (int i = 0; i < N; i++) begin
                  if (((mmask >> i) & 1) != 0 && ((win >> i) & 1) != ((mpat >> i) & 1))
                     hit[m] = 0;
               end
            end
            hbits[m] = (hbits[m] << 1) | int'(b);
            if (hlen[m] < 64) hlen[m]++;
            if (hit[m] && ov[m] == 0) hlen[m] = 0;
         end
         if (clr) begin
            mcnt[m] = 0;
            msat[m] = 0;
         end else if (hit[m]) begin
            if (mcnt[m] == cmax[m]) msat[m] = 1;
            else mcnt[m]++;
         end
      end
      if (ld) begin
         mpat  = p & 4'hF;
         mmask = mk & 4'hF;
      end
      e.da = hit[0]; e.ca = mcnt[0]; e.sa = msat[0];
      e.db = hit[1]; e.cb = mcnt[1]; e.sb = msat[1];
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic stream(input int unsigned bits, input int len, input string tag);
      for (int i = len - 1; i >= 0; i--) step(1, bits[i], 0, 0, 0, 0, tag);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, tag);
   endtask

   // Monitor: outputs are registered, so one expectation per clock edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, "det_a", int'(det_a), int'(e.da));
            chk(e.tag, "cnt_a", int'(cnt_a), e.ca);
            chk(e.tag, "sat_a", int'(sat_a), int'(e.sa));
            chk(e.tag, "det_b", int'(det_b), int'(e.db));
            chk(e.tag, "cnt_b", int'(cnt_b), e.cb);
            chk(e.tag, "sat_b", int'(sat_b), int'(e.sb));
            $display("t=%0t %s a:det=%0d cnt=%0d sat=%0d b:det=%0d cnt=%0d sat=%0d",
                     $time, e.tag, det_a, cnt_a, sat_a, det_b, cnt_b, sat_b);
         end
      end
   end

   initial begin
      do_reset("reset");
      do_reset("reset");

      stream(4'b1001, 4, "basic");
      idle(2, "basic_idle");

      do_reset("ovl_reset");
      stream(7'b1001001, 7, "overlap");
      idle(2, "overlap_idle");

      do_reset("gap_reset");
      step(1, 1, 0, 0, 0, 0, "gap"); idle(2, "gap");
      step(1, 0, 0, 0, 0, 0, "gap"); idle(1, "gap");
      step(1, 0, 0, 0, 0, 0, "gap"); idle(3, "gap");
      step(1, 1, 0, 0, 0, 0, "gap"); idle(2, "gap");

      step(1, 1, 1, 4'b1001, 4'b1011, 0, "mask_load");
      stream(4'b1101, 4, "mask_hit");
      idle(1, "mask_idle");
      step(0, 0, 1, 4'b1001, 4'b1011, 0, "mask_load2");
      stream(4'b1111, 4, "mask_miss");
      idle(1, "mask_idle");

      // All-zero mask: every sample with a full window matches.
      step(0, 0, 1, 4'b0000, 4'b0000, 0, "sat_load");
      for (int i = 0; i < 270; i++) step(1, 1'($urandom), 0, 0, 0, 0, "sat_run");
      step(0, 0, 0, 0, 0, 1, "clear");
      idle(1, "clear_idle");
      step(1, 0, 0, 0, 0, 0, "clr_pre");
      step(1, 1, 0, 0, 0, 1, "clr_hit");
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, (i == 3), "clr_mix");
      step(1, 1, 1, 4'b0110, 4'b1111, 1, "load_clear");
      stream(4'b0110, 4, "after_lc");

      do_reset("rst_mid");
      stream(3'b100, 3, "pre_rst");
      do_reset("rst_mid2");
      stream(4'b1001, 4, "post_rst");
      idle(1, "post_idle");

      for (int i = 0; i < 2000; i++) begin
         int unsigned r;
         r = $urandom_range(0, 999);
         if (r < 3) begin
            do_reset("rnd_reset");
         end else begin
            step(($urandom_range(0, 3) != 0), 1'($urandom),
                 ($urandom_range(0, 63) == 0), $urandom_range(0, 15),
                 (($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 4'hF),
                 ($urandom_range(0, 79) == 0), "random");
         end
      end

      repeat (3) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
